// File: rtl/output_layer_sequencer.sv
// output_layer_sequencer: serialises an input vector into a neuron layer and returns its latched result.
// Optional result-wait watchdog enabled by defining OUTPUT_LAYER_SEQ_WATCHDOG_EN.
`default_nettype none

module output_layer_sequencer #(
  parameter int NUM_INPUTS     = 4,
  parameter int NUM_OUTPUTS    = 2,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [NUM_INPUTS*WIDTH-1:0]    IN_VECTOR,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  output logic [WIDTH-1:0]               LAYER_VALUE,
  output logic                           LAYER_VALID,
  input  logic                           LAYER_READY,
  input  logic [NUM_OUTPUTS*WIDTH-1:0]   LAYER_VALUES,
  input  logic [NUM_OUTPUTS-1:0]         LAYER_VALIDS,
  input  logic                           LAYER_OVERFLOW,
  output logic [NUM_OUTPUTS*WIDTH-1:0]   OUT_VECTOR,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic                           OUT_OVERFLOW,
  output logic                           BUSY,
  output logic                           ERROR
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                         state, state_next;
  logic                           ready_en;
  logic [NUM_INPUTS*WIDTH-1:0]    in_reg;
  logic [IDX_W-1:0]               idx;
  logic                           ovf_acc;
  logic [NUM_OUTPUTS*WIDTH-1:0]   out_reg;
  logic                           out_ovf;
  logic                           all_valid;
  logic                           accept;
  logic                           timeout;

  assign all_valid   = &LAYER_VALIDS;
  // ready_en keeps IN_READY low until the first edge after reset release
  assign IN_READY    = ready_en && (state == S_IDLE);
  assign accept      = IN_VALID && IN_READY;
  assign LAYER_VALID = (state == S_FEED);
  assign LAYER_VALUE = (state == S_FEED) ? in_reg[idx*WIDTH +: WIDTH] : '0;
  assign OUT_VALID   = (state == S_HOLD);
  assign OUT_VECTOR  = out_reg;
  assign OUT_OVERFLOW = out_ovf;
  assign BUSY        = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
      in_reg   <= '0;
      idx      <= '0;
      ovf_acc  <= 1'b0;
      out_reg  <= '0;
      out_ovf  <= 1'b0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            in_reg  <= IN_VECTOR;
            idx     <= '0;
            ovf_acc <= 1'b0;
          end
        end
        S_FEED: begin
          ovf_acc <= ovf_acc | LAYER_OVERFLOW;
          if (LAYER_READY && (idx != LAST_IDX)) idx <= idx + 1'b1;
        end
        S_WAIT: begin
          ovf_acc <= ovf_acc | LAYER_OVERFLOW;
          if (all_valid) begin
            out_reg <= LAYER_VALUES;
            out_ovf <= ovf_acc | LAYER_OVERFLOW;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_FEED;
      S_FEED: if (LAYER_READY && (idx == LAST_IDX)) state_next = S_WAIT;
      S_WAIT: begin
        if (all_valid)    state_next = S_HOLD;
        else if (timeout) state_next = S_IDLE;
      end
      S_HOLD: if (OUT_READY) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

`ifdef OUTPUT_LAYER_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            error_q;

  // fires on the TIMEOUT_CYCLES-th WAIT cycle; a simultaneous result takes priority
  assign timeout = (state == S_WAIT) && !all_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign ERROR   = error_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (state != S_WAIT)  wd_cnt <= '0;
      else if (!timeout)    wd_cnt <= wd_cnt + 1'b1;
      if (accept)           error_q <= 1'b0;
      else if (timeout)     error_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  // constant-false expression; the timeout limit has no effect in this build
  assign ERROR   = (TIMEOUT_CYCLES < 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_output_layer_sequencer.sv
// Directed self-checking bench for output_layer_sequencer (NUM_INPUTS=4, NUM_OUTPUTS=2, WIDTH=8).
`default_nettype none

module tb_output_layer_sequencer;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic [31:0] IN_VECTOR;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  LAYER_VALUE;
  logic        LAYER_VALID;
  logic        LAYER_READY;
  logic [15:0] LAYER_VALUES;
  logic [1:0]  LAYER_VALIDS;
  logic        LAYER_OVERFLOW;
  logic [15:0] OUT_VECTOR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_OVERFLOW;
  logic        BUSY;
  logic        ERROR;

  output_layer_sequencer #(
    .NUM_INPUTS(4), .NUM_OUTPUTS(2), .WIDTH(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VECTOR(IN_VECTOR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .LAYER_VALUE(LAYER_VALUE), .LAYER_VALID(LAYER_VALID), .LAYER_READY(LAYER_READY),
    .LAYER_VALUES(LAYER_VALUES), .LAYER_VALIDS(LAYER_VALIDS), .LAYER_OVERFLOW(LAYER_OVERFLOW),
    .OUT_VECTOR(OUT_VECTOR), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_OVERFLOW(OUT_OVERFLOW), .BUSY(BUSY), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;

  // element 0 sits in the low byte
  localparam logic [31:0] VEC1 = {8'h7F, 8'h10, 8'hF8, 8'h08};
  localparam logic [31:0] VEC2 = {8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] exp1 [4] = '{8'h08, 8'hF8, 8'h10, 8'h7F};

  always @(posedge CLK) if (RSTN && LAYER_VALID && LAYER_READY) xfers <= xfers + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [31:0] vec);
    int n = 0;
    while (!IN_READY && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(IN_READY), 32'd1);
    IN_VECTOR = vec;
    IN_VALID  = 1'b1;
    tick();
    IN_VALID  = 1'b0;
  endtask

  // accept, feed 4 elements unstalled, return result next WAIT cycle; ends in HOLD
  task automatic run_job(input logic [31:0] vec, input logic [15:0] res);
    accept(vec);
    repeat (4) tick();
    LAYER_VALUES = res;
    LAYER_VALIDS = 2'b11;
    tick();
    LAYER_VALIDS = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    RSTN = 1'b0; IN_VECTOR = '0; IN_VALID = 1'b0; LAYER_READY = 1'b1;
    LAYER_VALUES = '0; LAYER_VALIDS = '0; LAYER_OVERFLOW = 1'b0; OUT_READY = 1'b1;
    tick(); tick();
    check("rst_in_ready", 32'(IN_READY), 0);
    check("rst_layer_value", 32'(LAYER_VALUE), 0);
    check("rst_layer_valid", 32'(LAYER_VALID), 0);
    check("rst_out_vector", 32'(OUT_VECTOR), 0);
    check("rst_out_valid", 32'(OUT_VALID), 0);
    check("rst_out_ovf", 32'(OUT_OVERFLOW), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_error", 32'(ERROR), 0);
    RSTN = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(IN_READY), 1);

    // basic job
    base = xfers;
    accept(VEC1);
    for (int k = 0; k < 4; k++) begin
      check("t1_layer_valid", 32'(LAYER_VALID), 1);
      check($sformatf("t1_elem%0d", k), 32'(LAYER_VALUE), 32'(exp1[k]));
      tick();
    end
    check("t1_wait_valid", 32'(LAYER_VALID), 0);
    check("t1_wait_busy", 32'(BUSY), 1);
    tick(); tick();
    LAYER_VALUES = {8'hE0, 8'h20};
    LAYER_VALIDS = 2'b11;
    tick();
    LAYER_VALIDS = 2'b00;
    check("t1_out_valid", 32'(OUT_VALID), 1);
    check("t1_out_vector", 32'(OUT_VECTOR), 32'h0000E020);
    check("t1_out_ovf", 32'(OUT_OVERFLOW), 0);
    check("t1_xfers", 32'(xfers - base), 4);
    tick();
    check("t1_out_valid_drop", 32'(OUT_VALID), 0);
    check("t1_idle_ready", 32'(IN_READY), 1);

    // layer backpressure on element 1
    base = xfers;
    accept(VEC1);
    check("t2_e0", 32'(LAYER_VALUE), 32'h08);
    tick();
    check("t2_e1_a", 32'(LAYER_VALUE), 32'hF8);
    LAYER_READY = 1'b0;
    tick();
    check("t2_e1_b", 32'(LAYER_VALUE), 32'hF8);
    tick();
    check("t2_e1_c", 32'(LAYER_VALUE), 32'hF8);
    LAYER_READY = 1'b1;
    tick();
    check("t2_e2", 32'(LAYER_VALUE), 32'h10);
    tick();
    check("t2_e3", 32'(LAYER_VALUE), 32'h7F);
    tick();
    check("t2_wait_valid", 32'(LAYER_VALID), 0);
    check("t2_xfers", 32'(xfers - base), 4);
    LAYER_VALUES = 16'h1122;
    LAYER_VALIDS = 2'b11;
    tick();
    LAYER_VALIDS = 2'b00;
    check("t2_out_vector", 32'(OUT_VECTOR), 32'h1122);
    tick();

    // overflow pulse during FEED, output backpressure
    OUT_READY = 1'b0;
    accept(VEC2);
    tick();
    LAYER_OVERFLOW = 1'b1;
    tick();
    LAYER_OVERFLOW = 1'b0;
    tick(); tick();
    check("t3_wait", 32'(LAYER_VALID), 0);
    LAYER_VALUES = 16'h5A3C;
    LAYER_VALIDS = 2'b11;
    tick();
    LAYER_VALIDS = 2'b00;
    LAYER_VALUES = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      check("t3_hold_valid", 32'(OUT_VALID), 1);
      check("t3_hold_vector", 32'(OUT_VECTOR), 32'h5A3C);
      check("t3_hold_ovf", 32'(OUT_OVERFLOW), 1);
      check("t3_hold_in_ready", 32'(IN_READY), 0);
      if (i == 5) OUT_READY = 1'b1;
      tick();
    end
    check("t3_released", 32'(OUT_VALID), 0);
    run_job(VEC1, 16'h1234);
    check("t3_next_vector", 32'(OUT_VECTOR), 32'h1234);
    check("t3_next_ovf", 32'(OUT_OVERFLOW), 0);
    tick();

    // partial valids
    accept(VEC1);
    repeat (4) tick();
    LAYER_VALUES = 16'h7F80;
    LAYER_VALIDS = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_partial_no_valid", 32'(OUT_VALID), 0);
    end
    check("t4_error_low", 32'(ERROR), 0);
    LAYER_VALIDS = 2'b11;
    tick();
    LAYER_VALIDS = 2'b00;
    check("t4_out_valid", 32'(OUT_VALID), 1);
    check("t4_out_vector", 32'(OUT_VECTOR), 32'h7F80);
    tick();

    // reset during FEED after element 2 is presented
    accept(VEC1);
    tick(); tick();
    check("t5_e2", 32'(LAYER_VALUE), 32'h10);
    #2 RSTN = 1'b0;
    #1;
    check("t5_async_valid", 32'(LAYER_VALID), 0);
    check("t5_async_value", 32'(LAYER_VALUE), 0);
    check("t5_async_busy", 32'(BUSY), 0);
    check("t5_async_in_ready", 32'(IN_READY), 0);
    check("t5_async_out_vector", 32'(OUT_VECTOR), 0);
    tick();
    RSTN = 1'b1;
    tick();
    check("t5_in_ready", 32'(IN_READY), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_no_stale_out", 32'(OUT_VALID), 0);
    end

`ifdef OUTPUT_LAYER_SEQ_WATCHDOG_EN
    accept(VEC2);
    repeat (4) tick();
    check("t6_in_wait", 32'(BUSY), 1);
    n = 0;
    while (!ERROR && n < 40) begin
      tick();
      n++;
    end
    check("t6_timeout_cycles", 32'(n), 16);
    check("t6_error", 32'(ERROR), 1);
    check("t6_idle", 32'(BUSY), 0);
    check("t6_out_valid", 32'(OUT_VALID), 0);
    check("t6_out_vector", 32'(OUT_VECTOR), 0);
    accept(VEC1);
    check("t6_error_cleared", 32'(ERROR), 0);
    repeat (4) tick();
    LAYER_VALUES = 16'h0102;
    LAYER_VALIDS = 2'b11;
    tick();
    LAYER_VALIDS = 2'b00;
    check("t6_recovered_vector", 32'(OUT_VECTOR), 32'h0102);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
